// File: rtl/mem_bus_initiator_pkg.sv
// Shared definitions for the memory bus initiator: bus widths, strobe
// constants, the controller state encoding and the strobe issue helper.
package mem_bus_initiator_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int WAIT_W = 16;

    localparam logic [STRB_W-1:0] RD_STRB  = 4'h0;
    localparam logic [STRB_W-1:0] ALL_STRB = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reads carry no strobes; a write with no lanes enabled is widened to a
    // full-word write so that a write can never look like a read on the bus.
    function automatic logic [STRB_W-1:0] issue_strb(input logic               write,
                                                     input logic [STRB_W-1:0] wstrb);
        if (!write)
            return RD_STRB;
        else if (wstrb == '0)
            return ALL_STRB;
        else
            return wstrb;
    endfunction

endpackage

// File: rtl/mem_bus_initiator_bus_watchdog.sv
// Bus wait counter with timeout compare. The count restarts on every new
// transaction and advances for each bus cycle that passes without ready.
// A limit of zero disables expiry.
module bus_watchdog
    import mem_bus_initiator_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              count_en,
    input  logic [WAIT_W-1:0] limit,
    output logic              expired
);

    logic [WAIT_W-1:0] wait_cnt;

    // Wait counter: clear has priority so a fresh transaction starts at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else if (count_en)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign expired = (limit != '0) && (wait_cnt == limit);

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding native-bus initiator. Accepts one command, drives it on
// the memory bus until ready or timeout, then holds the response until it is
// consumed before accepting the next command.
module mem_bus_initiator
    import mem_bus_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,

    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy
);

    localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    state_t state;
    state_t state_nxt;

    logic   accept;
    logic   complete;
    logic   abort;
    logic   expired;
    logic   wait_en;

    // State register; reset drops any bus request immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs; ready in the bus phase beats expiry.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        mem_valid_o = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        wait_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = resetn;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                mem_valid_o = 1'b1;
                wait_en     = !mem_ready_i;
                if (mem_ready_i) begin
                    complete  = 1'b1;
                    state_nxt = ST_RESP;
                end else if (expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance and held for the bus phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= RD_STRB;
        end else if (accept) begin
            mem_addr_o  <= cmd_addr;
            mem_wdata_o <= cmd_wdata;
            mem_wstrb_o <= issue_strb(cmd_write, cmd_wstrb);
        end
    end

    // Response capture; a zero issued strobe identifies a read, since writes
    // are never issued with an empty strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else if (complete) begin
            rsp_rdata   <= (mem_wstrb_o == RD_STRB) ? mem_rdata_i : '0;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
        end
    end

    bus_watchdog u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (accept),
        .count_en (wait_en),
        .limit    (TIMEOUT_LIMIT),
        .expired  (expired)
    );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Testbench for mem_bus_initiator: directed table of transactions, a reset
// sequence in the middle of a bus phase, and randomized transactions checked
// against a transaction-level reference model.
module tb_mem_bus_initiator;

    localparam int TO = 4;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rdy_dly: bus cycle index (0 = first) on which the responder is ready,
    // -1 = no responder. e_vcyc: expected number of cycles mem_valid_o is high.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_dly;
        logic [31:0] rdata;
        int          rsp_dly;
        bit          hold;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
        logic        e_to;
        int          e_vcyc;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] wstrb, int rdy_dly, logic [31:0] rdata,
                                int rsp_dly, bit hold, logic [3:0] e_strb,
                                logic [31:0] e_rdata, logic e_to, int e_vcyc);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.rdy_dly = rdy_dly; v.rdata = rdata; v.rsp_dly = rsp_dly; v.hold = hold;
        v.e_strb = e_strb; v.e_rdata = e_rdata; v.e_to = e_to; v.e_vcyc = e_vcyc;
        return v;
    endfunction

    // Transaction-level reference: what the bus and response must look like.
    function automatic vec_t with_expect(vec_t v);
        bit served;
        served = (v.rdy_dly >= 0) && (v.rdy_dly <= TO);
        if (!v.wr)              v.e_strb = 4'h0;
        else if (v.wstrb == 0)  v.e_strb = 4'hF;
        else                    v.e_strb = v.wstrb;
        v.e_vcyc  = served ? v.rdy_dly + 1 : TO + 1;
        v.e_to    = !served;
        v.e_rdata = (served && !v.wr) ? v.rdata : 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one command from IDLE through the response handshake.
    task automatic do_txn(input vec_t v);
        int n;
        cmd_valid   = 1'b1;
        cmd_write   = v.wr;
        cmd_addr    = v.addr;
        cmd_wdata   = v.wdata;
        cmd_wstrb   = v.wstrb;
        mem_ready_i = 1'($urandom % 2);
        mem_rdata_i = $urandom;
        rsp_ready   = 1'($urandom % 2);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        chk("busy_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;
        cmd_valid   = v.hold;
        rsp_ready   = 1'b0;
        chk("cmd_ready_bus", 32'(cmd_ready), 32'h0);
        n = 0;
        while (mem_valid_o === 1'b1 && n < 300) begin
            chk("mem_addr", mem_addr_o, v.addr);
            chk("mem_wdata", mem_wdata_o, v.wdata);
            chk("mem_wstrb", 32'(mem_wstrb_o), 32'(v.e_strb));
            chk("rsp_valid_bus", 32'(rsp_valid), 32'h0);
            mem_ready_i = (n == v.rdy_dly);
            mem_rdata_i = (n == v.rdy_dly) ? v.rdata : $urandom;
            @(posedge clk); #1;
            n++;
        end
        chk("valid_cycles", 32'(n), 32'(v.e_vcyc));
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rsp_timeout", 32'(rsp_timeout), 32'(v.e_to));
        chk("rsp_rdata", rsp_rdata, v.e_rdata);
        for (int i = 0; i < v.rsp_dly; i++) begin
            mem_ready_i = 1'($urandom % 2);
            mem_rdata_i = $urandom;
            @(posedge clk); #1;
            chk("rsp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("rsp_hold_rdata", rsp_rdata, v.e_rdata);
            chk("rsp_hold_timeout", 32'(rsp_timeout), 32'(v.e_to));
            chk("cmd_ready_resp", 32'(cmd_ready), 32'h0);
            chk("mem_valid_resp", 32'(mem_valid_o), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready   = 1'b0;
        mem_ready_i = 1'b0;
        chk("rsp_valid_done", 32'(rsp_valid), 32'h0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'h1);
        chk("busy_after", 32'(busy), 32'h0);
        chk("mem_valid_after", 32'(mem_valid_o), 32'h0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; mem_ready_i = 1'b0;
        mem_rdata_i = '0;

        tbl[0] = mk(1'b0, 32'h10000000, 32'h0,        4'h0, 0,  32'h00000001, 0,  1'b0, 4'h0, 32'h00000001, 1'b0, 1);
        tbl[1] = mk(1'b1, 32'h14000004, 32'h12345678, 4'h3, 4,  32'hDEADBEEF, 1,  1'b0, 4'h3, 32'h0,        1'b0, 5);
        tbl[2] = mk(1'b0, 32'h10000040, 32'h0,        4'h0, -1, 32'h0,        0,  1'b0, 4'h0, 32'h0,        1'b1, 5);
        tbl[3] = mk(1'b0, 32'h10000080, 32'h0,        4'h0, 4,  32'hCAFEF00D, 0,  1'b0, 4'h0, 32'hCAFEF00D, 1'b0, 5);
        tbl[4] = mk(1'b1, 32'h14000010, 32'hA5A5A5A5, 4'h0, 1,  32'h11111111, 0,  1'b0, 4'hF, 32'h0,        1'b0, 2);
        tbl[5] = mk(1'b0, 32'h10000100, 32'h0,        4'hF, 2,  32'h0BADC0DE, 3,  1'b0, 4'h0, 32'h0BADC0DE, 1'b0, 3);
        tbl[6] = mk(1'b1, 32'h14000020, 32'hFFFFFFFF, 4'hC, -1, 32'h22222222, 2,  1'b0, 4'hC, 32'h0,        1'b1, 5);
        tbl[7] = mk(1'b0, 32'h10000200, 32'h0,        4'h0, 0,  32'h33333333, 10, 1'b1, 4'h0, 32'h33333333, 1'b0, 1);
        tbl[8] = mk(1'b1, 32'h14000030, 32'h87654321, 4'h8, 3,  32'h44444444, 0,  1'b0, 4'h8, 32'h0,        1'b0, 4);

        // Reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb_o), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_cmd_ready", 32'(cmd_ready), 32'h1);

        // Directed table
        for (int i = 0; i < 9; i++) do_txn(tbl[i]);
        cmd_valid = 1'b0;

        // Reset pulse during the bus phase
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10000300;
        @(posedge clk); #1;
        cmd_valid = 1'b0; mem_ready_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_mem_valid", 32'(mem_valid_o), 32'h1);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_mem_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        chk("in_reset_mem_valid", 32'(mem_valid_o), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_reset_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("post_reset_no_rsp", 32'(rsp_valid), 32'h0);
        do_txn(tbl[0]);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            int r;
            rv.wr      = 1'($urandom % 2);
            rv.addr    = $urandom;
            rv.wdata   = $urandom;
            rv.wstrb   = 4'($urandom % 16);
            r          = int'($urandom_range(0, 6));
            rv.rdy_dly = (r == 6) ? -1 : r;
            rv.rdata   = $urandom;
            rv.rsp_dly = int'($urandom_range(0, 3));
            rv.hold    = 1'($urandom % 2);
            rv = with_expect(rv);
            do_txn(rv);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_initiator.md
MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum bus wait cycles (0 = timeout disabled, legal range 0..65535).
REQ-002 The block SHALL have port clk  input  1  the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-006 The block SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports cmd_addr / cmd_wdata  input  32 each  target address / write data.
REQ-008 The block SHALL have port cmd_wstrb  input  4  byte enables for a write.
REQ-009 The block SHALL have port rsp_valid  output  1  response available.
REQ-010 The block SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 The block SHALL have ports rsp_rdata  output  32  (read data) and rsp_timeout  output  1  (transaction aborted).
REQ-012 The block SHALL have native-bus initiator ports mem_valid_o (out 1), mem_ready_i (in 1), mem_addr_o (out 32), mem_wdata_o (out 32), mem_wstrb_o (out 4) and mem_rdata_i (in 32, OR-combined from responders).
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, BUS and RESP.
REQ-015 cmd_ready SHALL be high only in IDLE.
REQ-016 A handshake at edge k SHALL register addr, wdata and wstrb, enter BUS, and assert mem_valid_o from cycle k+1.
REQ-017 For a read, mem_wstrb_o SHALL be 4'h0.
REQ-018 For a write, mem_wstrb_o SHALL equal cmd_wstrb.
REQ-019 A write with cmd_wstrb = 0 SHALL be issued as 4'hF.
REQ-020 mem_addr_o, mem_wdata_o and mem_wstrb_o SHALL stay constant while mem_valid_o is high.
REQ-021 mem_valid_o SHALL remain high until mem_ready_i is sampled high or a timeout occurs.
REQ-022 mem_ready_i SHALL be ignored while mem_valid_o is low.
REQ-023 When mem_ready_i is sampled high in BUS, the block SHALL capture mem_rdata_i (reads only; 0 for writes), deassert mem_valid_o, and assert rsp_valid with rsp_timeout=0, all on the next edge.
REQ-024 Minimum latency SHALL be: accept edge k, then mem_valid_o at k+1, then rsp_valid at k+2 when ready is present in the first bus cycle.
REQ-025 A 16-bit wait counter SHALL clear on entry to BUS and increment each BUS cycle without ready.
REQ-026 When TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES with mem_ready_i low, the block SHALL deassert mem_valid_o and enter RESP with rsp_timeout=1 and rsp_rdata=0.
REQ-027 If mem_ready_i and the timeout condition coincide, ready SHALL win and rsp_timeout SHALL be 0.
REQ-028 rsp_valid, rsp_rdata and rsp_timeout SHALL hold stable in RESP until rsp_ready is high.
REQ-029 RESP SHALL go to IDLE on the rsp handshake.
REQ-030 cmd_ready SHALL first rise in the cycle after the rsp handshake, giving no command overlap and exactly one outstanding transaction.
REQ-031 cmd_valid SHALL be ignored outside IDLE, and commands SHALL never be dropped or duplicated.

Reset
REQ-032 resetn low SHALL asynchronously force IDLE and drive all outputs to 0, including mem_valid_o, which drops immediately mid-transaction.
REQ-033 resetn low SHALL clear the wait counter and response registers.
REQ-034 After resetn deasserts, cmd_ready SHALL be high on the first clock edge.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/BUS/RESP), the bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4) and the read strobe constant 4'h0.
REQ-036 One sub-module, bus_watchdog, SHALL implement the wait counter and the timeout compare, with inputs clear, count_en and limit and output expired.

Verification
REQ-037 The bench SHALL cover: read of 0x10000000, responder ready on the first bus cycle with rdata 0x00000001 -> rsp_valid at k+2, rsp_rdata=0x00000001, rsp_timeout=0, mem_wstrb_o=0.
REQ-038 The bench SHALL cover: write of 0x12345678 to 0x14000004 with wstrb 0x3, ready after 5 cycles -> mem_valid_o high for exactly 5 cycles, mem_wstrb_o=0x3, rsp_rdata=0.
REQ-039 The bench SHALL cover: TIMEOUT_CYCLES=4 with no responder -> mem_valid_o drops after the 5th bus cycle, rsp_timeout=1, rsp_rdata=0.
REQ-040 The bench SHALL cover: TIMEOUT_CYCLES=4 with ready arriving exactly on the expiry cycle -> rsp_timeout=0 and data captured.
REQ-041 The bench SHALL cover: rsp_ready held low for 10 cycles while cmd_valid stays high -> response stable, cmd_ready low throughout, second command accepted only after the rsp handshake.
REQ-042 The bench SHALL cover: resetn pulsed low during BUS -> mem_valid_o falls without a clock edge, no rsp_valid, cmd_ready=1 on the first edge after release.
